// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES wait states, and then
// answers with a one-cycle resp_valid. Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  stall,
    output logic                  misaligned
);

    localparam int         DEPTH     = 1 << (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;
    logic                  enter_resp;

    logic [DM_ADDRESS-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            funct3_q;
    logic                  write_q;

    logic [DM_ADDRESS-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [2:0]            acc_funct3;
    logic                  acc_write;

    logic                  byte_acc, half_acc, word_acc;
    logic                  mis;
    logic [1:0]            lane;
    logic [DM_ADDRESS-3:0] word_idx;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic                  mem_we;

    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           load_data;
    logic [31:0]           rdata_d;

    logic                  resp_valid_q;
    logic [31:0]           rdata_q;
    logic                  mis_q;

    logic [31:0]           mem_q [DEPTH];

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == IDLE);
        stall     = (state_q == WAIT) || ((state_q == IDLE) && req_valid);
    end

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_d == RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            write_q  <= req_write;
        end
    end

    // With zero wait states the access happens on the acceptance edge, so it uses the live request fields.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
            acc_write  = req_write;
        end else begin
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
            acc_funct3 = funct3_q;
            acc_write  = write_q;
        end
    end

    always_comb begin
        if (acc_write) begin
            byte_acc = (acc_funct3 == 3'b000);
            half_acc = (acc_funct3 == 3'b001);
        end else begin
            byte_acc = (acc_funct3 == 3'b000) || (acc_funct3 == 3'b100);
            half_acc = (acc_funct3 == 3'b001) || (acc_funct3 == 3'b101);
        end
        word_acc = !byte_acc && !half_acc;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis = (half_acc && acc_addr[0]) || (word_acc && (acc_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign lane     = acc_addr[1:0];
    assign word_idx = acc_addr[DM_ADDRESS-1:2];

    always_comb begin
        be     = 4'b1111;
        wlanes = acc_wdata;
        if (byte_acc) begin
            be     = 4'b0001 << lane;
            wlanes = {4{acc_wdata[7:0]}};
        end else if (half_acc) begin
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{acc_wdata[15:0]}};
        end
    end

    assign mem_we = enter_resp && acc_write && !mis && !reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rword = mem_q[word_idx];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (acc_funct3)
            3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_data = {24'd0, rbyte};
            3'b101:  load_data = {16'd0, rhalf};
            default: load_data = rword;
        endcase
        rdata_d = (acc_write || mis) ? '0 : load_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            mis_q        <= 1'b0;
        end else begin
            resp_valid_q <= enter_resp;
            mis_q        <= enter_resp && mis;
            if (enter_resp) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one with zero wait states.
// Expected values are hand-computed.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v2, v0, w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  f;

    logic        rdy2, rv2, st2, mis2;
    logic [31:0] rd2;
    logic        rdy0, rv0, st0, mis0;
    logic [31:0] rd0;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
        .clock(clk), .reset(rst), .req_valid(v2), .req_write(w), .req_addr(a),
        .req_wdata(d), .req_funct3(f), .req_ready(rdy2), .resp_valid(rv2),
        .resp_rdata(rd2), .stall(st2), .misaligned(mis2)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clk), .reset(rst), .req_valid(v0), .req_write(w), .req_addr(a),
        .req_wdata(d), .req_funct3(f), .req_ready(rdy0), .resp_valid(rv0),
        .resp_rdata(rd0), .stall(st0), .misaligned(mis0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one request to the selected instance and wait (bounded) for its response.
    task automatic xfer(input int sel, input logic wr, input logic [8:0] ad, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic mis,
                        output int lat, output int stalls);
        @(negedge clk);
        w = wr; a = ad; d = wd; f = f3;
        if (sel == 2) v2 = 1'b1; else v0 = 1'b1;
        #1;
        stalls = (sel == 2) ? int'(st2) : int'(st0);
        @(posedge clk);
        #1;
        v2 = 1'b0; v0 = 1'b0;
        lat = -1; rdata = '0; mis = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((sel == 2) ? st2 : st0) stalls++;
            if ((sel == 2) ? rv2 : rv0) begin
                lat   = i;
                rdata = (sel == 2) ? rd2 : rd0;
                mis   = (sel == 2) ? mis2 : mis0;
                break;
            end
        end
    endtask

    task automatic run(input int sel, input logic wr, input logic [8:0] ad, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_mis,
                       input string tag);
        logic [31:0] rdata;
        logic        mis;
        int          lat, stalls;
        int          exp_lat;
        exp_lat = (sel == 2) ? 3 : 1;
        xfer(sel, wr, ad, wd, f3, rdata, mis, lat, stalls);
        check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s.stall_cycles", tag), 32'(stalls), 32'(exp_lat));
        check($sformatf("%s.rdata", tag), rdata, exp_rd);
        check($sformatf("%s.misaligned", tag), {31'd0, mis}, {31'd0, exp_mis});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; v2 = 1'b0; v0 = 1'b0; w = 1'b0; a = '0; d = '0; f = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst.ready2", {31'd0, rdy2}, 32'd1);
        check("rst.valid2", {31'd0, rv2}, 32'd0);
        check("rst.rdata2", rd2, 32'd0);
        check("rst.mis2", {31'd0, mis2}, 32'd0);
        check("rst.stall2", {31'd0, st2}, 32'd0);
        check("rst.ready0", {31'd0, rdy0}, 32'd1);
        check("rst.stall0", {31'd0, st0}, 32'd0);
        v2 = 1'b1;
        #1 check("idle.stall_on_valid", {31'd0, st2}, 32'd1);
        v2 = 1'b0;
        #1 check("idle.stall_off", {31'd0, st2}, 32'd0);

        run(2, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, "sw_010");
        run(2, 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "lw_010");
        run(2, 1'b1, 9'h013, 32'h12345680, 3'b000, 32'h0, 1'b0, "sb_013");
        run(2, 1'b0, 9'h013, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, "lb_013");
        run(2, 1'b0, 9'h013, 32'h0, 3'b100, 32'h00000080, 1'b0, "lbu_013");
        run(2, 1'b0, 9'h011, 32'h0, 3'b100, 32'h000000BE, 1'b0, "lbu_011");
        run(2, 1'b0, 9'h010, 32'h0, 3'b010, 32'h80ADBEEF, 1'b0, "lw_010b");
        run(2, 1'b0, 9'h010, 32'h0, 3'b111, 32'h80ADBEEF, 1'b0, "ld_f111");

        run(2, 1'b1, 9'h020, 32'h5555AAAA, 3'b010, 32'h0, 1'b0, "sw_020");
        run(2, 1'b1, 9'h022, 32'hFFFF8001, 3'b001, 32'h0, 1'b0, "sh_022");
        run(2, 1'b0, 9'h022, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, "lh_022");
        run(2, 1'b0, 9'h022, 32'h0, 3'b101, 32'h00008001, 1'b0, "lhu_022");
        run(2, 1'b0, 9'h020, 32'h0, 3'b001, 32'hFFFFAAAA, 1'b0, "lh_020");
        run(2, 1'b0, 9'h020, 32'h0, 3'b010, 32'h8001AAAA, 1'b0, "lw_020");

        run(2, 1'b1, 9'h1FC, 32'h00000000, 3'b010, 32'h0, 1'b0, "sw_1fc");
        run(2, 1'b1, 9'h1FF, 32'h000000A5, 3'b000, 32'h0, 1'b0, "sb_1ff");
        run(2, 1'b0, 9'h1FF, 32'h0, 3'b000, 32'hFFFFFFA5, 1'b0, "lb_1ff");
        run(2, 1'b0, 9'h1FC, 32'h0, 3'b010, 32'hA5000000, 1'b0, "lw_1fc");

        run(0, 1'b1, 9'h030, 32'h01234567, 3'b010, 32'h0, 1'b0, "w0.sw_030");
        run(0, 1'b0, 9'h030, 32'h0, 3'b010, 32'h01234567, 1'b0, "w0.lw_030");

        // Zero wait states, req_valid held high: accept, respond, accept, respond...
        @(negedge clk);
        w = 1'b0; a = 9'h030; d = '0; f = 3'b001; v0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("w0.b2b%0d.ready", k), {31'd0, rdy0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("w0.b2b%0d.valid", k), {31'd0, rv0}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 1) check($sformatf("w0.b2b%0d.rdata", k), rd0, 32'h00004567);
            @(negedge clk);
        end
        v0 = 1'b0;
        @(negedge clk);
        check("w0.b2b.valid_drop", {31'd0, rv0}, 32'd0);

        run(2, 1'b1, 9'h040, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "sw_040");
        @(negedge clk);
        w = 1'b1; a = 9'h040; d = 32'h12345678; f = 3'b010; v2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
        @(negedge clk);
        check("abort.in_wait_stall", {31'd0, st2}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) check("abort.ready", {31'd0, rdy2}, 32'd1);
            if (rv2) seen++;
        end
        check("abort.no_resp", 32'(seen), 32'd0);
        run(2, 1'b0, 9'h040, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "abort.lw_040");

        run(2, 1'b0, 9'h041, 32'h0, 3'b000, 32'hFFFFFFF0, 1'b0, "lb_041");
`ifdef DMEM_MISALIGN_CHECK_EN
        run(2, 1'b0, 9'h041, 32'h0, 3'b010, 32'h0, 1'b1, "mis.lw_041");
        run(2, 1'b1, 9'h042, 32'h11111111, 3'b010, 32'h0, 1'b1, "mis.sw_042");
        run(2, 1'b0, 9'h040, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "mis.lw_040");
`else
        run(2, 1'b0, 9'h041, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "nomis.lw_041");
        run(2, 1'b1, 9'h042, 32'h11111111, 3'b010, 32'h0, 1'b0, "nomis.sw_042");
        run(2, 1'b0, 9'h040, 32'h0, 3'b010, 32'h11111111, 1'b0, "nomis.lw_040");
        run(2, 1'b0, 9'h041, 32'h0, 3'b100, 32'h00000011, 1'b0, "nomis.lbu_041");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
